ball_physics: RTL and testbench
===============================

# ball_physics

Parametrised ball motion and collision engine that replaces the fixed-size wall, platform and brick logic. On each `step` strobe from the game controller it:
- resolves wall and platform bounces;
- probes the brick-health memory around the ball's leading edges through a read/write port, decrementing each brick it hits;
- updates the ball's direction bits.

It sits between the ball position counter, the brick memory and the game controller. Every coordinate width and playfield dimension is a parameter.

## Interface
- `W`, 10: coordinate width in bits.
- `X_MAX`, 640: playfield width in pixels.
- `Y_MAX`, 480: playfield height in pixels.
- `BRICK_W`, 40: brick width in pixels.
- `BRICK_H`, 20: brick height in pixels.
- `BRICK_ROWS`, 8: rows of bricks. The brick area is `y < BRICK_ROWS*BRICK_H`.
- `PLAT_Y`, 440: platform top row.
- `PLAT_W`, 64: platform width.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `step`  in  1  start one evaluation. Ignored while `busy`.
- `ball_x`, `ball_y`  in  W  ball top-left corner.
- `size`  in  W  ball side length, 1 or more.
- `plat_x`  in  W  platform left edge.
- `busy`  out  1  evaluation in progress.
- `done`  out  1  one-cycle pulse at the end of an evaluation.
- `x_dir`, `y_dir`  out  1  1 means the coordinate is increasing.
- `miss`  out  1  one-cycle pulse together with `done` when the ball reached the bottom.
- `hit_count`  out  3  bricks hit in the last evaluation.
- `mem_rd`  out  1  brick read request.
- `mem_x`, `mem_y`  out  W  pixel coordinate being probed.
- `mem_health`  in  2  health of the probed brick, valid the cycle after `mem_rd`.
- `mem_wr`  out  1  write strobe.
- `mem_wr_health`  out  2  new health value (`mem_health-1`). Written to the brick at `mem_x`/`mem_y`.

## Operation
- States: IDLE, EVAL, PROBE_V1, WAIT_V1, PROBE_V2, WAIT_V2, PROBE_H1, WAIT_H1, PROBE_H2, WAIT_H2, [PROBE_C, WAIT_C], APPLY, DONE.
- IDLE: a `step` moves the machine to EVAL. `busy` is high in every state except IDLE.
- EVAL latches the ball inputs. All sums are computed at W+1 bits, so there is no wrap-around.
- EVAL wall rules:
  - `ball_x==0` sets `x_dir` to 1.
  - `ball_x+size>=X_MAX` sets `x_dir` to 0.
  - `ball_y==0` sets `y_dir` to 1.
  - `ball_y+size>=Y_MAX` sets `y_dir` to 0 and flags `miss`.
- EVAL platform rule: when `ball_y+size==PLAT_Y` and `ball_x+size>plat_x` and `ball_x<plat_x+PLAT_W`, set `y_dir` to 0.
- Leading edges:
  - `ey` is `ball_y+size` when `y_dir` is 1, otherwise `ball_y`.
  - `ex` is `ball_x+size` when `x_dir` is 1, otherwise `ball_x`.
- Vertical probes run only when `ey%BRICK_H==0`, `ey!=0` and `ey` lies in the brick area.
  - Probe row: `ey+1` when `y_dir` is 1, otherwise `ey-1`.
  - V1 probes x=`ball_x`.
  - V2 probes x=`ball_x+size-1`, and only when that point is in a different brick column from V1.
- Horizontal probes run only when `ex%BRICK_W==0`, `0<ex<X_MAX` and `ball_y` is in the brick area.
  - Probe column: `ex±1`, sign following `x_dir` as above.
  - H1 probes y=`ball_y`.
  - H2 probes y=`ball_y+size-1`, and only when that point is in a different brick row from H1.
- Skipped probes take zero cycles.
- Each PROBE state asserts `mem_rd` with a stable coordinate.
- Each WAIT state samples `mem_health`. If it is non-zero, that is a hit:
  - `mem_wr` pulses for one cycle with the same coordinate and `mem_wr_health=mem_health-1`;
  - `hit_count` increments;
  - a vertical hit sets the pending `flip_y`; a horizontal hit sets the pending `flip_x`.
- APPLY inverts `y_dir` when `flip_y` is set, and `x_dir` when `flip_x` is set.
- An axis already forced by a wall or the platform in this evaluation ignores its pending flip (the wall wins).
- DONE pulses `done`, and `miss` when flagged, then returns to IDLE.

## Timing
- Reset values: `x_dir`, `y_dir`, `busy`, `done`, `miss`, `mem_rd` and `mem_wr` are 0; `hit_count` is 0; `mem_x`, `mem_y` and `mem_wr_health` are 0; state is IDLE.
- Reset mid-evaluation aborts the evaluation. No `mem_rd` or `mem_wr` is asserted on the following cycle, and no `done` pulse occurs.
- A `step` sampled in cycle N puts the machine in EVAL at N+1.
  - With no probes, `done` is high at N+3.
  - Each executed probe adds 2 cycles, so the maximum without corner probing is N+11.
- Direction outputs and `hit_count` change at the APPLY→DONE edge, and are valid while `done` is high.
- `step` asserted while `busy` is dropped, not queued.

## Configuration
- `BALL_CORNER_PROBE_EN` defined: when both the vertical and horizontal probes were eligible and none of them hit, the machine probes the diagonal point (`ex±1`, `ey±1`).
  - A hit flips both axes, subject to the wall-wins rule.
  - This adds 2 cycles, so the maximum is `done` at N+13.
- `BALL_CORNER_PROBE_EN` undefined: the PROBE_C and WAIT_C states do not exist, and a ball meeting only a brick corner passes through it.

## Test plan
- Ball (0,300), dirs 0/0, `step` → `done` at N+3, `x_dir`=1, no `mem_rd`.
- Ball (100,420), size 20, dirs 1/1, `plat_x`=90 → `y_dir`=0 at `done`, `miss`=0.
- Ball (45,160), size 10, dirs 0/0, brick at row 7 col 1 health 2 → one `mem_rd` at (45,159), `mem_wr` of 1, `y_dir`=1, `hit_count`=1.
- Ball (35,160), size 10, two bricks health 1 at cols 0 and 1 → both written 0, `hit_count`=2, `y_dir` flips once, `done` at N+7.
- Ball (100,470), size 10, `y_dir`=1 → `miss` and `done` pulse together, `y_dir`=0; `reset` asserted at the WAIT_V1 cycle of another run → no `mem_wr`, no `done`, outputs zero.
- With `BALL_CORNER_PROBE_EN`: ball (70,150), size 10, dirs 1/1, brick health 3 only at (81,161) → probe at (81,161), write 2, both dirs flip, `done` at N+9.

Source files
------------

// File: rtl/ball_physics.sv
// Ball motion / collision engine: wall and platform bounces plus brick probing over a read/write port.
// Optional diagonal corner probe is enabled with `define BALL_CORNER_PROBE_EN.
//   state    | meaning
//   IDLE     | waiting for step
//   EVAL     | latch ball, apply wall/platform rules, plan probes
//   PROBE_*  | mem_rd with probe coordinate (V1/V2 vertical, H1/H2 horizontal, C corner)
//   WAIT_*   | sample mem_health, write back decremented health on a hit
//   APPLY    | commit directions and hit count
//   DONE     | pulse done (and miss)
module ball_physics #(
  parameter int W          = 10,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480,
  parameter int BRICK_W    = 40,
  parameter int BRICK_H    = 20,
  parameter int BRICK_ROWS = 8,
  parameter int PLAT_Y     = 440,
  parameter int PLAT_W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic [W-1:0] ball_x,
  input  logic [W-1:0] ball_y,
  input  logic [W-1:0] size,
  input  logic [W-1:0] plat_x,
  output logic         busy,
  output logic         done,
  output logic         x_dir,
  output logic         y_dir,
  output logic         miss,
  output logic [2:0]   hit_count,
  output logic         mem_rd,
  output logic [W-1:0] mem_x,
  output logic [W-1:0] mem_y,
  input  logic [1:0]   mem_health,
  output logic         mem_wr,
  output logic [1:0]   mem_wr_health
);

  localparam int W1 = W + 1;
  localparam logic [W:0]   XM   = W1'(X_MAX);
  localparam logic [W:0]   YM   = W1'(Y_MAX);
  localparam logic [W:0]   BW   = W1'(BRICK_W);
  localparam logic [W:0]   BH   = W1'(BRICK_H);
  localparam logic [W:0]   AREA = W1'(BRICK_ROWS * BRICK_H);
  localparam logic [W:0]   PY   = W1'(PLAT_Y);
  localparam logic [W:0]   PW   = W1'(PLAT_W);
  localparam logic [W:0]   ONE1 = W1'(1);
  localparam logic [W-1:0] ONE  = W'(1);

  typedef enum logic [3:0] {
    IDLE, EVAL,
    PROBE_V1, WAIT_V1, PROBE_V2, WAIT_V2,
    PROBE_H1, WAIT_H1, PROBE_H2, WAIT_H2,
`ifdef BALL_CORNER_PROBE_EN
    PROBE_C, WAIT_C,
`endif
    APPLY, DONE
  } state_t;

  state_t st, nxt, after_v, after_h;

  logic [W:0]   bx, by, sz, px, x_end, y_end, ex, ey;
  logic         wx, wy, fx_w, fy_w, miss_w, v_ok, v2_ok, h_ok, h2_ok;
  logic [W-1:0] vrow, hcol, v2x, h2y;

  logic         wx_r, wy_r, fx_f, fy_f, miss_r, h_en, v2_en, h2_en;
  logic         flip_x, flip_y, cur_hit;
  logic [W-1:0] vrow_r, hcol_r, v1x_r, v2x_r, h1y_r, h2y_r;
  logic [2:0]   hits;
`ifdef BALL_CORNER_PROBE_EN
  logic         v_en;
`endif

  // Evaluation arithmetic is one bit wider than the coordinates so edges never wrap.
  always_comb begin
    bx     = {1'b0, ball_x};
    by     = {1'b0, ball_y};
    sz     = {1'b0, size};
    px     = {1'b0, plat_x};
    x_end  = bx + sz;
    y_end  = by + sz;
    wx     = x_dir;
    wy     = y_dir;
    fx_w   = 1'b0;
    fy_w   = 1'b0;
    miss_w = 1'b0;
    if (bx == '0) begin wx = 1'b1; fx_w = 1'b1; end
    if (x_end >= XM) begin wx = 1'b0; fx_w = 1'b1; end
    if (by == '0) begin wy = 1'b1; fy_w = 1'b1; end
    if (y_end >= YM) begin wy = 1'b0; fy_w = 1'b1; miss_w = 1'b1; end
    if ((y_end == PY) && (x_end > px) && (bx < px + PW)) begin
      wy   = 1'b0;
      fy_w = 1'b1;
    end
    ey    = wy ? y_end : by;
    ex    = wx ? x_end : bx;
    vrow  = wy ? ey[W-1:0] + ONE : ey[W-1:0] - ONE;
    hcol  = wx ? ex[W-1:0] + ONE : ex[W-1:0] - ONE;
    v2x   = ball_x + size - ONE;
    h2y   = ball_y + size - ONE;
    // The bottom edge of the brick area still counts, so a ball just below it can hit row 7.
    v_ok  = ((ey % BH) == '0) && (ey != '0) && (ey <= AREA);
    v2_ok = v_ok && ((bx / BW) != ((x_end - ONE1) / BW));
    h_ok  = ((ex % BW) == '0) && (ex != '0) && (ex < XM) && (by < AREA);
    h2_ok = h_ok && ((by / BH) != ((y_end - ONE1) / BH));
  end

  assign cur_hit = ((st == WAIT_V1) || (st == WAIT_V2) || (st == WAIT_H1) || (st == WAIT_H2)
`ifdef BALL_CORNER_PROBE_EN
                    || (st == WAIT_C)
`endif
                   ) && (mem_health != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    after_h = APPLY;
`ifdef BALL_CORNER_PROBE_EN
    if (v_en && h_en && (hits == 3'd0) && !cur_hit) after_h = PROBE_C;
`endif
    after_v = h_en ? PROBE_H1 : after_h;
    nxt     = st;
    unique case (st)
      IDLE:     if (step) nxt = EVAL;
      EVAL:     nxt = v_ok ? PROBE_V1 : (h_ok ? PROBE_H1 : APPLY);
      PROBE_V1: nxt = WAIT_V1;
      WAIT_V1:  nxt = v2_en ? PROBE_V2 : after_v;
      PROBE_V2: nxt = WAIT_V2;
      WAIT_V2:  nxt = after_v;
      PROBE_H1: nxt = WAIT_H1;
      WAIT_H1:  nxt = h2_en ? PROBE_H2 : after_h;
      PROBE_H2: nxt = WAIT_H2;
      WAIT_H2:  nxt = after_h;
`ifdef BALL_CORNER_PROBE_EN
      PROBE_C:  nxt = WAIT_C;
      WAIT_C:   nxt = APPLY;
`endif
      APPLY:    nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wx_r <= 1'b0;  wy_r <= 1'b0;  fx_f <= 1'b0;  fy_f <= 1'b0;  miss_r <= 1'b0;
      h_en <= 1'b0;  v2_en <= 1'b0; h2_en <= 1'b0;
      vrow_r <= '0;  hcol_r <= '0;  v1x_r <= '0;  v2x_r <= '0;  h1y_r <= '0;  h2y_r <= '0;
      hits <= '0;    flip_x <= 1'b0; flip_y <= 1'b0;
      x_dir <= 1'b0; y_dir <= 1'b0; hit_count <= '0;
`ifdef BALL_CORNER_PROBE_EN
      v_en <= 1'b0;
`endif
    end else begin
      unique case (st)
        EVAL: begin
          wx_r <= wx;    wy_r <= wy;    fx_f <= fx_w;  fy_f <= fy_w;  miss_r <= miss_w;
          h_en <= h_ok;  v2_en <= v2_ok; h2_en <= h2_ok;
          vrow_r <= vrow; hcol_r <= hcol; v1x_r <= ball_x; v2x_r <= v2x;
          h1y_r <= ball_y; h2y_r <= h2y;
          hits <= '0;    flip_x <= 1'b0; flip_y <= 1'b0;
`ifdef BALL_CORNER_PROBE_EN
          v_en <= v_ok;
`endif
        end
        WAIT_V1, WAIT_V2: if (cur_hit) begin hits <= hits + 3'd1; flip_y <= 1'b1; end
        WAIT_H1, WAIT_H2: if (cur_hit) begin hits <= hits + 3'd1; flip_x <= 1'b1; end
`ifdef BALL_CORNER_PROBE_EN
        WAIT_C: if (cur_hit) begin
          hits <= hits + 3'd1; flip_x <= 1'b1; flip_y <= 1'b1;
        end
`endif
        APPLY: begin
          // A wall or platform already decided this axis, so brick flips on it are dropped.
          x_dir     <= wx_r ^ (flip_x & ~fx_f);
          y_dir     <= wy_r ^ (flip_y & ~fy_f);
          hit_count <= hits;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_x  = '0;
    mem_y  = '0;
    mem_rd = 1'b0;
    unique case (st)
      PROBE_V1, WAIT_V1: begin mem_x = v1x_r;  mem_y = vrow_r; end
      PROBE_V2, WAIT_V2: begin mem_x = v2x_r;  mem_y = vrow_r; end
      PROBE_H1, WAIT_H1: begin mem_x = hcol_r; mem_y = h1y_r;  end
      PROBE_H2, WAIT_H2: begin mem_x = hcol_r; mem_y = h2y_r;  end
`ifdef BALL_CORNER_PROBE_EN
      PROBE_C,  WAIT_C:  begin mem_x = hcol_r; mem_y = vrow_r; end
`endif
      default: ;
    endcase
    if ((st == PROBE_V1) || (st == PROBE_V2) || (st == PROBE_H1) || (st == PROBE_H2)
`ifdef BALL_CORNER_PROBE_EN
        || (st == PROBE_C)
`endif
       ) mem_rd = 1'b1;
  end

  assign busy          = (st != IDLE);
  assign done          = (st == DONE);
  assign miss          = done & miss_r;
  assign mem_wr        = cur_hit;
  assign mem_wr_health = cur_hit ? mem_health - 2'd1 : 2'd0;

endmodule

// File: tb/tb_ball_physics.sv
// Directed testbench for ball_physics with a behavioural brick-health memory.
module tb_ball_physics;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset, step;
  logic [W-1:0] ball_x, ball_y, size, plat_x;
  logic         busy, done, x_dir, y_dir, miss, mem_rd, mem_wr;
  logic [2:0]   hit_count;
  logic [W-1:0] mem_x, mem_y;
  logic [1:0]   mem_health, mem_wr_health;

  ball_physics dut (
    .clk(clk), .reset(reset), .step(step),
    .ball_x(ball_x), .ball_y(ball_y), .size(size), .plat_x(plat_x),
    .busy(busy), .done(done), .x_dir(x_dir), .y_dir(y_dir), .miss(miss),
    .hit_count(hit_count), .mem_rd(mem_rd), .mem_x(mem_x), .mem_y(mem_y),
    .mem_health(mem_health), .mem_wr(mem_wr), .mem_wr_health(mem_wr_health)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Brick memory: rows of 20 px, columns of 40 px; read data valid the cycle after mem_rd.
  logic [1:0] health [0:63][0:31];
  logic       clr_req = 1'b0, ld_req = 1'b0;
  int         ld_r = 0, ld_c = 0;
  logic [1:0] ld_v = 2'd0;

  always @(posedge clk) begin
    mem_health <= mem_rd ? health[mem_y / 20][mem_x / 40] : 2'd0;
    if (mem_wr) health[mem_y / 20][mem_x / 40] = mem_wr_health;
    if (clr_req)
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 32; c++) health[r][c] = 2'd0;
    if (ld_req) health[ld_r][ld_c] = ld_v;
  end

  int           rd_cnt = 0, wr_cnt = 0, done_cnt = 0, miss_bad = 0, done_cyc = 0;
  logic [W-1:0] rd_x [0:63], rd_y [0:63], wr_x [0:63], wr_y [0:63];
  logic [1:0]   wr_h [0:63];
  logic         d_x = 1'b0, d_y = 1'b0, d_miss = 1'b0;
  logic [2:0]   d_hit = 3'd0;

  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      rd_x[rd_cnt % 64] = mem_x;
      rd_y[rd_cnt % 64] = mem_y;
      rd_cnt++;
    end
    if (mem_wr === 1'b1) begin
      wr_x[wr_cnt % 64] = mem_x;
      wr_y[wr_cnt % 64] = mem_y;
      wr_h[wr_cnt % 64] = mem_wr_health;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      d_x      = x_dir;
      d_y      = y_dir;
      d_hit    = hit_count;
      d_miss   = miss;
    end
    if ((miss === 1'b1) && (done !== 1'b1)) miss_bad++;
  end

  int checks = 0, errors = 0;
  int rd0, wr0, dn0, step_edge, dl;

  task automatic clear_bricks();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic load_brick(input int r, input int c, input logic [1:0] v);
    @(negedge clk); ld_r = r; ld_c = c; ld_v = v; ld_req = 1'b1;
    @(negedge clk); ld_req = 1'b0;
  endtask

  // delta = edges from the step-sampling edge to the edge that raised done (N+3 -> 2).
  task automatic run_step(input logic [W-1:0] bx, input logic [W-1:0] by,
                          input logic [W-1:0] sz, input logic [W-1:0] px, output int delta);
    @(negedge clk);
    ball_x = bx; ball_y = by; size = sz; plat_x = px; step = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(posedge clk); #1;
    step = 1'b0;
    step_edge = cyc;
    delta = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt != dn0) begin
        delta = done_cyc - step_edge;
        break;
      end
    end
    checks++;
    if (delta < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done, required done within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step = 1'b0;
    ball_x = '0; ball_y = '0; size = 10'd10; plat_x = '0;
    clear_bricks();
    repeat (3) @(negedge clk);
    checks++;
    if ({x_dir, y_dir, busy, done, miss, mem_rd, mem_wr, hit_count, mem_x, mem_y, mem_wr_health} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got x%b y%b busy%b done%b miss%b rd%b wr%b hit%0d mx%0d my%0d wh%0d, required all 0",
               x_dir, y_dir, busy, done, miss, mem_rd, mem_wr, hit_count, mem_x, mem_y, mem_wr_health);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wall_bounce();
    run_step(10'd0, 10'd300, 10'd10, 10'd200, dl);
    checks++; if (dl !== 2) begin errors++; $display("FAIL wall_latency: got %0d required 2", dl); end
    checks++; if ({d_x, d_y} !== 2'b10) begin errors++; $display("FAIL wall_dirs: got %b required 10", {d_x, d_y}); end
    checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL wall_no_rd: got %0d reads required 0", rd_cnt - rd0); end
    checks++; if ({d_miss, d_hit} !== 4'd0) begin errors++; $display("FAIL wall_miss_hit: got %b required 0000", {d_miss, d_hit}); end
  endtask

  task automatic test_platform();
    run_step(10'd0, 10'd0, 10'd10, 10'd200, dl);
    checks++; if ({d_x, d_y} !== 2'b11) begin errors++; $display("FAIL corner_wall_dirs: got %b required 11", {d_x, d_y}); end
    run_step(10'd100, 10'd420, 10'd20, 10'd90, dl);
    checks++; if ({d_x, d_y, d_miss} !== 3'b100) begin errors++; $display("FAIL plat_bounce: got x,y,miss=%b required 100", {d_x, d_y, d_miss}); end
    checks++; if (dl !== 2) begin errors++; $display("FAIL plat_latency: got %0d required 2", dl); end
    run_step(10'd0, 10'd0, 10'd10, 10'd120, dl);
    run_step(10'd100, 10'd420, 10'd20, 10'd120, dl);
    checks++; if ({d_x, d_y} !== 2'b11) begin errors++; $display("FAIL plat_edge_touch: got %b required 11", {d_x, d_y}); end
  endtask

  task automatic test_single_brick();
    run_step(10'd630, 10'd470, 10'd10, 10'd0, dl);
    checks++; if ({d_x, d_y, d_miss} !== 3'b001) begin errors++; $display("FAIL far_corner: got x,y,miss=%b required 001", {d_x, d_y, d_miss}); end
    clear_bricks();
    load_brick(7, 1, 2'd2);
    run_step(10'd45, 10'd160, 10'd10, 10'd0, dl);
    checks++; if (dl !== 4) begin errors++; $display("FAIL brick1_latency: got %0d required 4", dl); end
    checks++; if ((rd_cnt - rd0 !== 1) || (rd_x[rd0 % 64] !== 10'd45) || (rd_y[rd0 % 64] !== 10'd159)) begin
      errors++; $display("FAIL brick1_read: got %0d reads first (%0d,%0d) required 1 read at (45,159)",
                         rd_cnt - rd0, rd_x[rd0 % 64], rd_y[rd0 % 64]);
    end
    checks++; if ((wr_cnt - wr0 !== 1) || (wr_h[wr0 % 64] !== 2'd1) || (wr_x[wr0 % 64] !== 10'd45) || (wr_y[wr0 % 64] !== 10'd159)) begin
      errors++; $display("FAIL brick1_write: got %0d writes first %0d at (%0d,%0d) required 1 write of 1 at (45,159)",
                         wr_cnt - wr0, wr_h[wr0 % 64], wr_x[wr0 % 64], wr_y[wr0 % 64]);
    end
    checks++; if ({d_x, d_y, d_hit} !== 5'b01_001) begin errors++; $display("FAIL brick1_result: got x%b y%b hit%0d required x0 y1 hit1", d_x, d_y, d_hit); end
    checks++; if (health[7][1] !== 2'd1) begin errors++; $display("FAIL brick1_mem: got %0d required 1", health[7][1]); end
  endtask

  task automatic test_two_bricks();
    run_step(10'd630, 10'd470, 10'd10, 10'd0, dl);
    clear_bricks();
    load_brick(7, 0, 2'd1);
    load_brick(7, 1, 2'd1);
    run_step(10'd35, 10'd160, 10'd10, 10'd0, dl);
    checks++; if (dl !== 6) begin errors++; $display("FAIL brick2_latency: got %0d required 6", dl); end
    checks++; if ((rd_cnt - rd0 !== 2) || (rd_x[(rd0 + 1) % 64] !== 10'd44) || (rd_y[(rd0 + 1) % 64] !== 10'd159)) begin
      errors++; $display("FAIL brick2_reads: got %0d reads second (%0d,%0d) required 2 reads second (44,159)",
                         rd_cnt - rd0, rd_x[(rd0 + 1) % 64], rd_y[(rd0 + 1) % 64]);
    end
    checks++; if ((wr_cnt - wr0 !== 2) || (wr_h[wr0 % 64] !== 2'd0) || (wr_h[(wr0 + 1) % 64] !== 2'd0)) begin
      errors++; $display("FAIL brick2_writes: got %0d writes required 2 writes of 0", wr_cnt - wr0);
    end
    checks++; if ({d_x, d_y, d_hit} !== 5'b01_010) begin errors++; $display("FAIL brick2_result: got x%b y%b hit%0d required x0 y1 hit2", d_x, d_y, d_hit); end
    checks++; if ({health[7][0], health[7][1]} !== 4'd0) begin errors++; $display("FAIL brick2_mem: got %0d,%0d required 0,0", health[7][0], health[7][1]); end
  endtask

  task automatic test_miss();
    run_step(10'd0, 10'd0, 10'd10, 10'd0, dl);
    run_step(10'd100, 10'd470, 10'd10, 10'd0, dl);
    checks++; if ({d_miss, d_y} !== 2'b10) begin errors++; $display("FAIL miss_pulse: got miss,y=%b required 10", {d_miss, d_y}); end
    checks++; if (dl !== 2) begin errors++; $display("FAIL miss_latency: got %0d required 2", dl); end
    checks++; if (miss_bad !== 0) begin errors++; $display("FAIL miss_without_done: got %0d required 0", miss_bad); end
  endtask

  task automatic test_reset_mid();
    logic saw_rd;
    clear_bricks();
    load_brick(7, 1, 2'd2);
    @(negedge clk);
    ball_x = 10'd45; ball_y = 10'd160; size = 10'd10; plat_x = 10'd0; step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    saw_rd = mem_rd;
    checks++; if (saw_rd !== 1'b1) begin errors++; $display("FAIL midrst_probe: got mem_rd %b required 1", saw_rd); end
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge clk); reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if ({rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0} !== 96'd0) begin
      errors++; $display("FAIL midrst_quiet: got rd %0d wr %0d done %0d required 0 0 0", rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0);
    end
    checks++; if ({x_dir, y_dir, busy, hit_count, mem_x, mem_y} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got x%b y%b busy%b hit%0d mx%0d my%0d required all 0", x_dir, y_dir, busy, hit_count, mem_x, mem_y);
    end
  endtask

  task automatic test_corner();
    run_step(10'd0, 10'd0, 10'd10, 10'd0, dl);
    clear_bricks();
    load_brick(8, 2, 2'd3);
    run_step(10'd70, 10'd150, 10'd10, 10'd0, dl);
`ifdef BALL_CORNER_PROBE_EN
    checks++; if (dl !== 8) begin errors++; $display("FAIL corner_latency: got %0d required 8", dl); end
    checks++; if ((rd_cnt - rd0 !== 3) || (rd_x[(rd0 + 2) % 64] !== 10'd81) || (rd_y[(rd0 + 2) % 64] !== 10'd161)) begin
      errors++; $display("FAIL corner_reads: got %0d reads third (%0d,%0d) required 3 reads third (81,161)",
                         rd_cnt - rd0, rd_x[(rd0 + 2) % 64], rd_y[(rd0 + 2) % 64]);
    end
    checks++; if ((wr_cnt - wr0 !== 1) || (wr_h[wr0 % 64] !== 2'd2)) begin errors++; $display("FAIL corner_write: got %0d writes required 1 write of 2", wr_cnt - wr0); end
    checks++; if ({d_x, d_y, d_hit} !== 5'b00_001) begin errors++; $display("FAIL corner_result: got x%b y%b hit%0d required x0 y0 hit1", d_x, d_y, d_hit); end
    checks++; if (health[8][2] !== 2'd2) begin errors++; $display("FAIL corner_mem: got %0d required 2", health[8][2]); end
`else
    checks++; if (dl !== 6) begin errors++; $display("FAIL corner_latency: got %0d required 6", dl); end
    checks++; if ((rd_cnt - rd0 !== 2) || (rd_x[(rd0 + 1) % 64] !== 10'd81) || (rd_y[(rd0 + 1) % 64] !== 10'd150)) begin
      errors++; $display("FAIL corner_reads: got %0d reads second (%0d,%0d) required 2 reads second (81,150)",
                         rd_cnt - rd0, rd_x[(rd0 + 1) % 64], rd_y[(rd0 + 1) % 64]);
    end
    checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL corner_write: got %0d writes required 0", wr_cnt - wr0); end
    checks++; if ({d_x, d_y, d_hit} !== 5'b11_000) begin errors++; $display("FAIL corner_result: got x%b y%b hit%0d required x1 y1 hit0", d_x, d_y, d_hit); end
    checks++; if (health[8][2] !== 2'd3) begin errors++; $display("FAIL corner_mem: got %0d required 3", health[8][2]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic seen_busy;
    @(negedge clk);
    ball_x = 10'd630; ball_y = 10'd470; size = 10'd10; plat_x = 10'd0; step = 1'b1;
    dn0 = done_cnt;
    @(posedge clk); #1; step = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    seen_busy = busy;
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", seen_busy); end
    checks++; if (done_cnt - dn0 !== 1) begin errors++; $display("FAIL b2b_dropped: got %0d done pulses required 1", done_cnt - dn0); end
    checks++; if ({busy, x_dir, y_dir, d_miss} !== 4'b0001) begin
      errors++; $display("FAIL b2b_final: got busy%b x%b y%b miss%b required busy0 x0 y0 miss1", busy, x_dir, y_dir, d_miss);
    end
  endtask

  initial begin
    reset = 1'b1; step = 1'b0;
    ball_x = '0; ball_y = '0; size = 10'd10; plat_x = '0;
    test_reset();
    test_wall_bounce();
    test_platform();
    test_single_brick();
    test_two_bricks();
    test_miss();
    test_reset_mid();
    test_corner();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
